seg_scan_ctrl: RTL

//  Time-multiplexed scan controller feeding the hex-to-7-segment decoder stage.

---
 rtl/seg_scan_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an NDIG-digit hex display.
// A clock divider produces one tick per digit slot; each tick advances the digit
// index. Writes go into a shadow buffer through a valid/ready handshake and are
// copied into the active buffer only at the end of a frame, so a frame never tears.
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits; digit 0
// is always shown). When undefined the blanking logic is not built.
module seg_scan_ctrl #(
    parameter int NDIG = 8,
    parameter int DIV  = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 wr_en,
    output logic                 wr_ready,
    input  logic [4*NDIG-1:0]    wr_data,
    input  logic [NDIG-1:0]      wr_dot,
    output logic [3:0]           hex_out,
    output logic                 dot_out,
    output logic [NDIG-1:0]      an
);

    localparam int              CNT_W    = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [2:0]      IDX_LAST = 3'(NDIG - 1);

    typedef enum logic {IDLE, PEND} hs_state_t;

    logic [CNT_W-1:0]   div_cnt_reg;
    logic [2:0]         idx_reg;
    logic [4*NDIG-1:0]  active_data_reg;
    logic [NDIG-1:0]    active_dot_reg;
    logic [4*NDIG-1:0]  shadow_data_reg;
    logic [NDIG-1:0]    shadow_dot_reg;
    hs_state_t          state_reg;
    hs_state_t          state_next;

    logic               tick;
    logic               frame_end;
    logic               accept;
    logic               slot_blank;
    logic [3:0]         act_digit [NDIG];

    assign tick      = en && (div_cnt_reg == DIV_LAST);
    assign frame_end = tick && (idx_reg == IDX_LAST);
    assign accept    = wr_en && wr_ready;

    // Split the active buffer into per-digit nibbles for indexed selection.
    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            assign act_digit[gi] = active_data_reg[4*gi +: 4];
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    logic [NDIG-1:0] digit_nz;
    logic [NDIG-1:0] blank_vec;

    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_nz
            assign digit_nz[gi] = (act_digit[gi] != 4'h0) || active_dot_reg[gi];
        end
    endgenerate

    // A digit above 0 is blank while it and every higher digit is zero with no dot.
    always_comb begin
        logic keep;
        keep      = 1'b0;
        blank_vec = '0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            keep         = keep | digit_nz[i];
            blank_vec[i] = ~keep;
        end
    end

    assign slot_blank = blank_vec[idx_reg];
`else
    assign slot_blank = 1'b0;
`endif

    // Slot divider and digit index; both freeze while the scan is halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
            idx_reg     <= '0;
        end else if (en) begin
            if (tick) begin
                div_cnt_reg <= '0;
                idx_reg     <= (idx_reg == IDX_LAST) ? 3'd0 : idx_reg + 3'd1;
            end else begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
            end
        end
    end

    // Shadow capture on accept; active buffer reloads only at a frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_data_reg <= '0;
            shadow_dot_reg  <= '0;
            active_data_reg <= '0;
            active_dot_reg  <= '0;
        end else begin
            if (accept) begin
                shadow_data_reg <= wr_data;
                shadow_dot_reg  <= wr_dot;
            end
            if (frame_end && state_reg == PEND) begin
                active_data_reg <= shadow_data_reg;
                active_dot_reg  <= shadow_dot_reg;
            end
        end
    end

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Handshake next state: accept moves to PEND, the commit at frame end returns to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = PEND;
            PEND:    if (frame_end) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake output: ready only when no write is waiting for its frame boundary.
    always_comb begin
        wr_ready = (state_reg == IDLE);
    end

    // Display decode from registered state; everything dark during reset or halt.
    always_comb begin
        hex_out = 4'h0;
        dot_out = 1'b0;
        an      = '1;
        if (!rst) begin
            hex_out = act_digit[idx_reg];
            dot_out = active_dot_reg[idx_reg];
            if (en && !slot_blank) an = ~(NDIG'(1) << idx_reg);
        end
    end

endmodule
